// File: rtl/regwrite_scheduler.sv
// regwrite_scheduler: arbitrates the regfile write port between WB and buffered muldiv results, tracking pending muldiv destinations
module regwrite_scheduler #(
  parameter int WORD_LEN = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_write,
  input  logic [4:0]                    wb_dest,
  input  logic [WORD_LEN-1:0]           wb_data,
  output logic                          wb_hold,
  input  logic                          md_valid,
  input  logic [4:0]                    md_dest,
  input  logic [WORD_LEN-1:0]           md_data,
  output logic                          md_ready,
  input  logic                          md_issue,
  input  logic [4:0]                    md_issue_dest,
  input  logic [4:0]                    id_rs,
  input  logic [4:0]                    id_rt,
  input  logic [4:0]                    id_dest,
  input  logic                          id_write,
  output logic                          id_stall,
  output logic                          rf_write,
  output logic [4:0]                    rf_dest,
  output logic [WORD_LEN-1:0]           rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   md_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]          fdest [FIFO_DEPTH];
  logic [WORD_LEN-1:0] fdata [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [AW:0]         count;
  logic [SW-1:0]       starve_cnt;
  logic [31:0]         pending, clr, set, pend_m;
  logic                nonempty, starve, pop, push, issue_ok;
  // Grant, handshake and hazard detection; outputs are forced quiet while reset is held
  always_comb begin
    nonempty = count != '0;
    starve = nonempty && starve_cnt == SW'(STARVE_LIMIT);
    pop = rst_n && nonempty && (starve || !wb_write);
    md_ready = rst_n && count < (AW+1)'(FIFO_DEPTH);
    push = md_valid && md_ready;
    clr = pop ? 32'd1 << fdest[rd_ptr] : '0;
    pend_m = pending & ~clr;
    id_stall = pend_m[id_rs] | pend_m[id_rt] | (id_write & pend_m[id_dest]) | (md_issue & pend_m[md_issue_dest]);
    issue_ok = md_issue && !id_stall && md_issue_dest != 5'd0;
    set = issue_ok ? 32'd1 << md_issue_dest : '0;
    rf_write = rst_n && (pop || wb_write);
    wb_hold = pop && wb_write;
    rf_dest = !rst_n ? '0 : pop ? fdest[rd_ptr] : wb_dest;
    rf_wdata = !rst_n ? '0 : pop ? fdata[rd_ptr] : wb_data;
    md_count = count;
  end
  // Result buffer storage; contents are meaningless once count says empty
  always_ff @(posedge clk) begin
    if (push) begin
      fdest[wr_ptr] <= md_dest;
      fdata[wr_ptr] <= md_data;
    end
  end
  // Pointers, occupancy, starvation age of the head and the pending-write scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      starve_cnt <= '0;
      pending <= '0;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      starve_cnt <= (pop || !nonempty) ? '0 : starve_cnt == SW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + SW'(1);
      pending <= ((pending & ~clr) | set) & ~32'd1;
    end
  end
endmodule

// File: tb/tb_regwrite_scheduler.sv
// tb_regwrite_scheduler: scenario tasks with a queue of expected muldiv regfile writes
module tb_regwrite_scheduler;
  logic        clk, rst_n, wb_write, wb_hold, md_valid, md_ready, md_issue, id_write, id_stall, rf_write;
  logic [4:0]  wb_dest, md_dest, md_issue_dest, id_rs, id_rt, id_dest, rf_dest;
  logic [31:0] wb_data, md_data, rf_wdata;
  logic [1:0]  md_count;
  int tests = 0, fails = 0;
  logic [36:0] md_q[$];
  logic [36:0] exp_w;

  regwrite_scheduler #(.WORD_LEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .wb_write(wb_write), .wb_dest(wb_dest), .wb_data(wb_data), .wb_hold(wb_hold),
    .md_valid(md_valid), .md_dest(md_dest), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_dest(md_issue_dest), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_write(id_write), .id_stall(id_stall), .rf_write(rf_write), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
    .md_count(md_count));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task idle;
    wb_write = 0; wb_dest = 0; wb_data = 0;
    md_valid = 0; md_dest = 0; md_data = 0;
    md_issue = 0; md_issue_dest = 0;
    id_rs = 0; id_rt = 0; id_dest = 0; id_write = 0;
  endtask

  task test_reset;
    idle;
    rst_n = 0;
    wb_write = 1; wb_dest = 3; wb_data = 32'h55; md_valid = 1; md_dest = 4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if ({md_ready, rf_write, wb_hold, id_stall} !== 4'b0) begin fails++; $display("FAIL reset_ctl got %b want 0000", {md_ready, rf_write, wb_hold, id_stall}); end
    tests++; if ({md_count, rf_dest, rf_wdata} !== 39'd0) begin fails++; $display("FAIL reset_data got cnt=%0d dest=%0d data=%0h want 0", md_count, rf_dest, rf_wdata); end
    #2;
    rst_n = 1;
    idle;
    step;
    @(negedge clk);
    tests++; if ({md_ready, md_count, rf_write} !== 4'b1000) begin fails++; $display("FAIL release got ready=%b cnt=%0d wr=%b want 1,0,0", md_ready, md_count, rf_write); end
    step;
  endtask

  task test_md_basic;
    md_valid = 1; md_dest = 5; md_data = 32'h1234;
    @(negedge clk);
    tests++; if ({md_ready, rf_write} !== 2'b10) begin fails++; $display("FAIL basic_push got ready=%b wr=%b want 1,0", md_ready, rf_write); end
    md_q.push_back({5'd5, 32'h1234});
    step;
    md_valid = 0;
    @(negedge clk);
    tests++; if (rf_write !== 1'b1 || md_q.size() == 0) begin fails++; $display("FAIL basic_write got wr=%b want 1", rf_write); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL basic_data got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    tests++; if (md_count !== 2'd1) begin fails++; $display("FAIL basic_cnt1 got %0d want 1", md_count); end
    step;
    @(negedge clk);
    tests++; if ({md_count, rf_write} !== 3'b000) begin fails++; $display("FAIL basic_drain got cnt=%0d wr=%b want 0,0", md_count, rf_write); end
    step;
  endtask

  task test_starve;
    wb_write = 1; wb_dest = 1; wb_data = 100; md_valid = 1; md_dest = 7; md_data = 32'hBEEF;
    @(negedge clk);
    tests++; if ({rf_write, wb_hold, rf_dest} !== {2'b10, 5'd1}) begin fails++; $display("FAIL starve_c0 got wr=%b hold=%b dest=%0d want 1,0,1", rf_write, wb_hold, rf_dest); end
    md_q.push_back({5'd7, 32'hBEEF});
    step;
    md_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      wb_dest = 5'(i + 1); wb_data = 32'(i);
      @(negedge clk);
      tests++; if ({rf_write, wb_hold, rf_dest, rf_wdata, md_count} !== {2'b10, 5'(i + 1), 32'(i), 2'd1}) begin fails++; $display("FAIL starve_wb%0d got wr=%b hold=%b dest=%0d data=%0h cnt=%0d want WB grant", i, rf_write, wb_hold, rf_dest, rf_wdata, md_count); end
      step;
    end
    wb_dest = 10; wb_data = 32'hAAAA;
    @(negedge clk);
    tests++; if ({rf_write, wb_hold} !== 2'b11 || md_q.size() == 0) begin fails++; $display("FAIL starve_grant got wr=%b hold=%b want 1,1", rf_write, wb_hold); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL starve_data got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    step;
    @(negedge clk);
    tests++; if ({rf_write, wb_hold, rf_dest, rf_wdata, md_count} !== {2'b10, 5'd10, 32'hAAAA, 2'd0}) begin fails++; $display("FAIL starve_held got wr=%b hold=%b dest=%0d data=%0h cnt=%0d want 1,0,10,aaaa,0", rf_write, wb_hold, rf_dest, rf_wdata, md_count); end
    step;
    idle;
  endtask

  task test_full;
    wb_write = 1; wb_dest = 2; wb_data = 1;
    md_valid = 1; md_dest = 3; md_data = 32'h3333;
    @(negedge clk);
    tests++; if (md_ready !== 1'b1) begin fails++; $display("FAIL full_r0 got %b want 1", md_ready); end
    md_q.push_back({5'd3, 32'h3333});
    step;
    md_dest = 4; md_data = 32'h4444;
    @(negedge clk);
    tests++; if ({md_ready, md_count} !== 3'b101) begin fails++; $display("FAIL full_r1 got ready=%b cnt=%0d want 1,1", md_ready, md_count); end
    md_q.push_back({5'd4, 32'h4444});
    step;
    md_dest = 6; md_data = 32'h6666;
    @(negedge clk);
    tests++; if ({md_ready, md_count} !== 3'b010) begin fails++; $display("FAIL full_cnt2 got ready=%b cnt=%0d want 0,2", md_ready, md_count); end
    step;
    wb_write = 0;
    @(negedge clk);
    tests++; if ({md_ready, rf_write} !== 2'b01 || md_q.size() == 0) begin fails++; $display("FAIL full_pop1 got ready=%b wr=%b want 0,1", md_ready, rf_write); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL full_d1 got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    step;
    @(negedge clk);
    tests++; if ({md_ready, md_count} !== 3'b101) begin fails++; $display("FAIL full_pp got ready=%b cnt=%0d want 1,1", md_ready, md_count); end
    md_q.push_back({5'd6, 32'h6666});
    tests++; if (rf_write !== 1'b1 || md_q.size() == 0) begin fails++; $display("FAIL full_pop2 got wr=%b want 1", rf_write); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL full_d2 got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    step;
    md_valid = 0;
    @(negedge clk);
    tests++; if ({md_count, rf_write} !== 3'b011 || md_q.size() == 0) begin fails++; $display("FAIL full_pop3 got cnt=%0d wr=%b want 1,1", md_count, rf_write); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL full_d3 got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    step;
    @(negedge clk);
    tests++; if ({md_count, rf_write} !== 3'b000) begin fails++; $display("FAIL full_empty got cnt=%0d wr=%b want 0,0", md_count, rf_write); end
    step;
    idle;
  endtask

  task test_scoreboard;
    md_issue = 1; md_issue_dest = 8;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL sb_issue got %b want 0", id_stall); end
    step;
    md_issue = 0; id_rs = 8;
    @(negedge clk);
    tests++; if (id_stall !== 1'b1) begin fails++; $display("FAIL sb_rs got %b want 1", id_stall); end
    step;
    id_rs = 0; id_rt = 8;
    @(negedge clk);
    tests++; if (id_stall !== 1'b1) begin fails++; $display("FAIL sb_rt got %b want 1", id_stall); end
    step;
    id_rt = 0; id_dest = 8;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL sb_nowrite got %b want 0", id_stall); end
    id_write = 1;
    #1;
    tests++; if (id_stall !== 1'b1) begin fails++; $display("FAIL sb_waw got %b want 1", id_stall); end
    md_valid = 1; md_dest = 8; md_data = 32'h88;
    md_q.push_back({5'd8, 32'h88});
    step;
    md_valid = 0; id_rs = 8;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL sb_popcycle got %b want 0", id_stall); end
    tests++; if (rf_write !== 1'b1 || md_q.size() == 0) begin fails++; $display("FAIL sb_pop got wr=%b want 1", rf_write); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL sb_data got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    step;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL sb_cleared got %b want 0", id_stall); end
    step;
    idle;
  endtask

  task test_corner;
    md_issue = 1; md_issue_dest = 0;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL r0_issue got %b want 0", id_stall); end
    step;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL r0_again got %b want 0", id_stall); end
    step;
    md_issue_dest = 9;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL r9_issue got %b want 0", id_stall); end
    step;
    md_valid = 1; md_dest = 9; md_data = 32'h99;
    @(negedge clk);
    tests++; if (id_stall !== 1'b1) begin fails++; $display("FAIL r9_reissue got %b want 1", id_stall); end
    md_q.push_back({5'd9, 32'h99});
    step;
    md_valid = 0;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL r9_popissue got %b want 0", id_stall); end
    tests++; if (rf_write !== 1'b1 || md_q.size() == 0) begin fails++; $display("FAIL r9_pop got wr=%b want 1", rf_write); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL r9_data got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    step;
    md_issue = 0; id_rs = 9; md_valid = 1; md_data = 32'h999;
    @(negedge clk);
    tests++; if (id_stall !== 1'b1) begin fails++; $display("FAIL r9_setwins got %b want 1", id_stall); end
    md_q.push_back({5'd9, 32'h999});
    step;
    md_valid = 0;
    @(negedge clk);
    tests++; if (rf_write !== 1'b1 || id_stall !== 1'b0 || md_q.size() == 0) begin fails++; $display("FAIL r9_pop2 got wr=%b stall=%b want 1,0", rf_write, id_stall); end
    else begin exp_w = md_q.pop_front(); if ({rf_dest, rf_wdata} !== exp_w) begin fails++; $display("FAIL r9_data2 got %0h want %0h", {rf_dest, rf_wdata}, exp_w); end end
    step;
    @(negedge clk);
    tests++; if (id_stall !== 1'b0) begin fails++; $display("FAIL r9_clear got %b want 0", id_stall); end
    step;
    idle;
  endtask

  task test_reset_mid;
    wb_write = 1; wb_dest = 1; wb_data = 32'h77;
    md_valid = 1; md_dest = 11; md_data = 32'hB; md_issue = 1; md_issue_dest = 13;
    md_q.push_back({5'd11, 32'hB});
    step;
    md_issue = 0; md_dest = 12; md_data = 32'hC;
    md_q.push_back({5'd12, 32'hC});
    step;
    md_valid = 0; id_rs = 13;
    @(negedge clk);
    tests++; if ({md_count, id_stall} !== 3'b101) begin fails++; $display("FAIL mid_before got cnt=%0d stall=%b want 2,1", md_count, id_stall); end
    #2;
    rst_n = 0;
    #1;
    tests++; if ({md_count, md_ready, rf_write, wb_hold, id_stall} !== 6'b0) begin fails++; $display("FAIL mid_async got cnt=%0d ready=%b wr=%b hold=%b stall=%b want 0", md_count, md_ready, rf_write, wb_hold, id_stall); end
    tests++; if ({rf_dest, rf_wdata} !== 37'd0) begin fails++; $display("FAIL mid_rf got %0h want 0", {rf_dest, rf_wdata}); end
    md_q.delete();
    @(negedge clk);
    rst_n = 1;
    wb_write = 0;
    step;
    @(negedge clk);
    tests++; if ({md_count, md_ready, id_stall, rf_write} !== 5'b00100) begin fails++; $display("FAIL mid_after got cnt=%0d ready=%b stall=%b wr=%b want 0,1,0,0", md_count, md_ready, id_stall, rf_write); end
    step;
    idle;
  endtask

  initial begin
    test_reset;
    test_md_basic;
    test_starve;
    test_full;
    test_scoreboard;
    test_corner;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regwrite_scheduler.md
# regwrite_scheduler

Schedules the register file's single write port between the in-order writeback stage and the multi-cycle multiply/divide unit, and keeps a pending-write scoreboard that stalls decode on hazards against outstanding multi-cycle results. It sits between WB, the muldiv result interface and the regfile write port (write/dest/wdata). The regfile commits on the falling clock edge. The decode stage reads the regfile combinationally.

## Interface
- `WORD_LEN`, 32, data width
- `FIFO_DEPTH`, 2, muldiv result buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, cycles a buffered muldiv result may wait before it preempts WB (≥1)

- `clk` in 1: the only clock; all state updates on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `wb_write` in 1, `wb_dest` in 5, `wb_data` in WORD_LEN: WB stage write request
- `wb_hold` out 1: WB write not taken this cycle; WB holds its request unchanged next cycle
- `md_valid` in 1, `md_dest` in 5, `md_data` in WORD_LEN, `md_ready` out 1: muldiv result handshake
- `md_issue` in 1, `md_issue_dest` in 5: decode issues a muldiv op targeting this register
- `id_rs`, `id_rt`, `id_dest` in 5, `id_write` in 1: decode-stage operands and destination
- `id_stall` out 1: decode must hold
- `rf_write` out 1, `rf_dest` out 5, `rf_wdata` out WORD_LEN: to the regfile write port
- `md_count` out log2(FIFO_DEPTH)+1: buffered muldiv results

## Operation
- FIFO:
  - A muldiv result is pushed when `md_valid & md_ready`.
  - `md_ready = (count < FIFO_DEPTH)`, derived from the registered count only. There is no push-through-pop when full.
- Grant, combinational from registered state and current inputs:
  - The default priority is WB. If `wb_write=1`, then `rf_*` = `wb_*`.
  - Otherwise, if the FIFO is non-empty, `rf_*` = FIFO head and the head pops at the rising edge.
  - Starvation override: if `starve_cnt == STARVE_LIMIT` and the FIFO is non-empty, the FIFO head is granted and popped. In that cycle `wb_hold = wb_write`.
- `starve_cnt`:
  - Increments each cycle the FIFO is non-empty and not granted, saturating at STARVE_LIMIT.
  - Clears on any pop and whenever the FIFO is empty.
- Scoreboard `pending[31:0]`:
  - `pending[0]` is hardwired to 0.
  - Set at the rising edge on an accepted issue, defined as `md_issue & ~id_stall & (md_issue_dest != 0)`.
  - Cleared at the rising edge when a FIFO pop writes that register.
  - If set and clear hit the same register in the same cycle, set wins.
- `id_stall` = any of the following, where `pend'` is `pending` with the register currently being written by a FIFO pop masked off (the negedge write precedes the decode read):
  - `pend'[id_rs]`
  - `pend'[id_rt]`
  - `id_write & pend'[id_dest]` (WAW)
  - `md_issue & pend'[md_issue_dest]`
- Dest 0 results are written through unchanged. The regfile discards them.

## Timing
- Reset asserted, asynchronously:
  - The FIFO empties, `pending` = 0 and `starve_cnt` = 0.
  - `md_ready`=0, `rf_write`=0, `wb_hold`=0, `id_stall`=0, `md_count`=0, and `rf_dest`/`rf_wdata` = 0.
  - Any in-flight FIFO contents are discarded.
- The first cycle after `rst_n` rises: `md_ready`=1.
- Latency:
  - WB to the regfile: 0 cycles (same-cycle pass-through).
  - Muldiv to the regfile: at least 1 cycle. It is written in the cycle after the push, at that cycle's falling edge.
- A muldiv result is not held off indefinitely. Worst-case wait from reaching the FIFO head is STARVE_LIMIT+1 cycles.
- `md_count` reflects registered state and updates at the rising edge. Push and pop in the same cycle leave it unchanged.
- `wb_hold` is only ever high when `wb_write` is high.

## Test plan
- Reset release, then muldiv result (dest 5, 0x1234), WB idle: `md_ready`=1 from the first cycle; `rf_write`=1, `rf_dest`=5, `rf_wdata`=0x1234 the next cycle; `md_count` returns 0.
- WB writes every cycle, one muldiv result buffered, STARVE_LIMIT=4:
  - WB is granted for 4 cycles.
  - In the 5th cycle the FIFO head is granted with `wb_hold`=1.
  - WB's held write lands the following cycle.
- Push 2 results without pops (WB busy): `md_count`=2 and `md_ready`=0; a third `md_valid` is not accepted until a pop.
- Issue to $8, then decode with `id_rs`=8: `id_stall`=1 until the $8 result pops. In the pop cycle `id_stall`=0, and `pending[8]` clears at the edge.
- Hazard and reset corner cases:
  - Issue to $0: no stall ever.
  - Issue to $9 while `pending[9]`=1: `id_stall`=1 and the issue is ignored.
  - Same-cycle clear and set of $9 leaves `pending[9]`=1.
  - `rst_n` low mid-buffer clears all state asynchronously.
